conv_result_writer: RTL



---
 rtl/conv_result_writer_pkg.sv | 28 ++
 rtl/conv_result_writer_tile_pos_counter.sv | 68 ++++++
 rtl/conv_result_writer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/conv_result_writer_pkg.sv
// Shared constants, state encoding and stream bit positions for the
// convolution result writer.
package conv_result_writer_pkg;

  localparam int S2P_SIZE    = 4;
  localparam int RESULT_SIZE = 32;
  localparam int ADDR_W      = 16;
  localparam int PIX_W       = 12;
  localparam int KN_W        = 8;
  localparam int TN_W        = 10;

  localparam int ROW_W = (S2P_SIZE > 1) ? $clog2(S2P_SIZE) : 1;

  // Wide enough to hold pixel/kernel indices and the counts they are compared to.
  localparam int PXL_W = ((TN_W + ROW_W) > PIX_W) ? (TN_W + ROW_W) : PIX_W;
  localparam int KRN_W = KN_W + ROW_W;

  localparam int VLD_PAD = 0;
  localparam int VLD_RAW = 1;
  localparam int VLD_SOT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } wr_state_e;

endpackage

// File: rtl/conv_result_writer_tile_pos_counter.sv
// Tracks the in-tile position (row fastest, then col) and the t/w tile indices
// of the incoming result stream, with stall, wrap and start-of-tile resync.
module tile_pos_counter
  import conv_result_writer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  input  logic              sot,
  input  logic [TN_W-1:0]   t_num,
  input  logic [KN_W-1:0]   w_num,
  output logic [ROW_W-1:0]  row,
  output logic [ROW_W-1:0]  col,
  output logic [TN_W-1:0]   t_tile,
  output logic [KN_W-1:0]   w_tile,
  output logic              sot_mis,
  output logic              tile_end,
  output logic              t_last,
  output logic              w_last,
  output logic              last_beat
);

  localparam logic [ROW_W-1:0] LAST_POS = ROW_W'(S2P_SIZE - 1);

  logic [ROW_W-1:0] row_q;
  logic [ROW_W-1:0] col_q;

  // A start-of-tile marker away from (0,0) makes the current beat position (0,0).
  assign sot_mis   = sot && ((row_q != '0) || (col_q != '0));
  assign row       = sot_mis ? '0 : row_q;
  assign col       = sot_mis ? '0 : col_q;
  assign tile_end  = (row == LAST_POS) && (col == LAST_POS);
  assign t_last    = (t_tile == (t_num - 1'b1));
  assign w_last    = (w_tile == (w_num - 1'b1));
  assign last_beat = tile_end && t_last && w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q  <= '0;
      col_q  <= '0;
      t_tile <= '0;
      w_tile <= '0;
    end else if (clear) begin
      row_q  <= '0;
      col_q  <= '0;
      t_tile <= '0;
      w_tile <= '0;
    end else if (advance) begin
      if (row == LAST_POS) begin
        row_q <= '0;
        col_q <= (col == LAST_POS) ? '0 : col + ROW_W'(1);
      end else begin
        row_q <= row + ROW_W'(1);
        col_q <= col;
      end
      if (tile_end) begin
        if (t_last) begin
          t_tile <= '0;
          w_tile <= w_last ? '0 : w_tile + 1'b1;
        end else begin
          t_tile <= t_tile + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/conv_result_writer.sv
// Drains serialized result tiles into the output feature buffer in
// kernel-major order, dropping padded elements.
module conv_result_writer
  import conv_result_writer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [PIX_W-1:0]       out_pixels,
  input  logic [KN_W-1:0]        kernel_nums,
  input  logic [TN_W-1:0]        img2col_t_num,
  input  logic [KN_W-1:0]        img2col_w_num,
  input  logic [RESULT_SIZE-1:0] in_result,
  input  logic [2:0]             in_valid,
  input  logic                   in_conv_done,
  output logic                   wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [RESULT_SIZE-1:0] wr_data,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  wr_state_e         state;

  logic [ADDR_W-1:0] base_q;
  logic [PIX_W-1:0]  out_pix_q;
  logic [KN_W-1:0]   kn_q;
  logic [TN_W-1:0]   t_num_q;
  logic [KN_W-1:0]   w_num_q;
  logic              conv_done_q;

  logic [ROW_W-1:0]  row;
  logic [ROW_W-1:0]  col;
  logic [TN_W-1:0]   t_tile;
  logic [KN_W-1:0]   w_tile;
  logic              sot_mis;
  logic              tile_end;
  logic              t_last;
  logic              w_last;
  logic              last_beat;

  logic [ADDR_W-1:0] wbase_q;
  logic [ADDR_W-1:0] kbase_q;
  logic [ADDR_W-1:0] kbase_cur;
  logic [ADDR_W-1:0] tile_step;
  logic [ADDR_W-1:0] addr_nxt;
  logic [PXL_W-1:0]  pixel;
  logic [KRN_W-1:0]  kernel;
  logic              accept;
  logic              write_ok;
  logic              conv_rise;

  // A start pulse always takes priority over a beat arriving in the same cycle.
  assign accept    = (state == ST_RUN) && in_valid[VLD_RAW] && !start;
  assign conv_rise = in_conv_done && !conv_done_q;

  assign pixel     = PXL_W'(t_tile) * PXL_W'(S2P_SIZE) + PXL_W'(row);
  assign kernel    = KRN_W'(w_tile) * KRN_W'(S2P_SIZE) + KRN_W'(col);
  assign write_ok  = in_valid[VLD_PAD] && (pixel < PXL_W'(out_pix_q)) && (kernel < KRN_W'(kn_q));

  assign tile_step = ADDR_W'(out_pix_q) * ADDR_W'(S2P_SIZE);
  assign kbase_cur = sot_mis ? wbase_q : kbase_q;
  assign addr_nxt  = base_q + kbase_cur + ADDR_W'(pixel);

  tile_pos_counter u_pos (
    .clk       (clk),
    .rst       (rst),
    .clear     (start),
    .advance   (accept),
    .sot       (in_valid[VLD_SOT]),
    .t_num     (t_num_q),
    .w_num     (w_num_q),
    .row       (row),
    .col       (col),
    .t_tile    (t_tile),
    .w_tile    (w_tile),
    .sot_mis   (sot_mis),
    .tile_end  (tile_end),
    .t_last    (t_last),
    .w_last    (w_last),
    .last_beat (last_beat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q    <= '0;
      out_pix_q <= '0;
      kn_q      <= '0;
      t_num_q   <= '0;
      w_num_q   <= '0;
    end else if (start) begin
      base_q    <= base_addr;
      out_pix_q <= out_pixels;
      kn_q      <= kernel_nums;
      t_num_q   <= img2col_t_num;
      w_num_q   <= img2col_w_num;
    end
  end

  // kbase_q tracks kernel*out_pixels, wbase_q tracks w_tile*S2P_SIZE*out_pixels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbase_q <= '0;
      kbase_q <= '0;
    end else if (start) begin
      wbase_q <= '0;
      kbase_q <= '0;
    end else if (accept) begin
      if (tile_end) begin
        if (t_last && w_last) begin
          wbase_q <= '0;
          kbase_q <= '0;
        end else if (t_last) begin
          wbase_q <= wbase_q + tile_step;
          kbase_q <= wbase_q + tile_step;
        end else begin
          kbase_q <= wbase_q;
        end
      end else if (row == ROW_W'(S2P_SIZE - 1)) begin
        kbase_q <= kbase_cur + ADDR_W'(out_pix_q);
      end else begin
        kbase_q <= kbase_cur;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= accept && write_ok;
      if (accept && write_ok) begin
        wr_addr <= addr_nxt;
        wr_data <= in_result;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      conv_done_q <= 1'b0;
    end else begin
      done        <= 1'b0;
      conv_done_q <= in_conv_done;
      case (state)
        ST_RUN: begin
          if (start) begin
            err <= 1'b1;
          end else begin
            if ((accept && sot_mis) || (conv_rise && !(accept && last_beat))) begin
              err <= 1'b1;
            end
            if (accept && last_beat) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          if (start) begin
            state <= ST_RUN;
            busy  <= 1'b1;
            err   <= 1'b0;
          end else begin
            if (in_valid[VLD_RAW]) begin
              err <= 1'b1;
            end
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
